program_loader: RTL

//  Upstream feeder for the 8-bit CPU's Load/data_in port. Takes a byte stream from a host
//  (UART/JTAG bridge) over a valid/ready handshake and parses address-tagged records.

---
 rtl/program_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Host-to-CPU program loader: parses SYNC/ADDR/COUNT/DATA/CSUM records from a
// byte stream and writes each data byte into the CPU's unified memory.
module program_loader #(
  parameter int              ADDR_W      = 5,
  parameter int              DATA_W      = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5,
  parameter int              TIMEOUT_CYC = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              Load,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              error
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DATA_W:0] MEM_DEPTH = (DATA_W + 1)'(1 << ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_COUNT, S_DATA, S_CSUM, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    rem_q, rem_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                run_q, run_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                hs;
  logic                in_record;
  logic [DATA_W-1:0]   sum;
  logic [DATA_W:0]     span;

  assign hs        = in_valid & in_ready;
  assign in_record = (state_q == S_ADDR) || (state_q == S_COUNT) ||
                     (state_q == S_DATA) || (state_q == S_CSUM);
  assign sum       = acc_q + in_data;
  // ptr_q still holds the base address while the COUNT byte is examined
  assign span      = (DATA_W + 1)'(ptr_q) + (DATA_W + 1)'(in_data);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ptr_q   <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    tmo_d   = '0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    run_d   = run_q;
    done_d  = 1'b0;
    err_d   = err_q;

    if (in_record && !hs) tmo_d = tmo_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (hs && in_data == SYNC_BYTE) begin
          state_d = S_ADDR;
          acc_d   = '0;
          err_d   = 1'b0;
          run_d   = 1'b0;
        end
      end
      S_ADDR: begin
        if (hs) begin
          if (in_data[DATA_W-1:ADDR_W] != '0) begin
            state_d = S_ERR;
          end else begin
            ptr_d   = PTR_W'(in_data[ADDR_W-1:0]);
            acc_d   = sum;
            state_d = S_COUNT;
          end
        end
      end
      S_COUNT: begin
        if (hs) begin
          if (in_data == '0 || span > MEM_DEPTH) begin
            state_d = S_ERR;
          end else begin
            rem_d   = PTR_W'(in_data);
            acc_d   = sum;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (hs) begin
          we_d    = 1'b1;
          addr_d  = ptr_q[ADDR_W-1:0];
          wdata_d = in_data;
          ptr_d   = ptr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          acc_d   = sum;
          if (rem_q == PTR_W'(1)) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (hs) begin
          if (sum == '0) begin
            done_d  = 1'b1;
            run_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Idle limit is counted from the last accepted byte; a byte on the limit cycle still counts
    if (in_record && !hs && tmo_q == TMO_W'(TIMEOUT_CYC - 1)) state_d = S_ERR;

    if (state_d == S_ERR) begin
      err_d = 1'b1;
      run_d = 1'b0;
    end
  end

  always_comb begin
    in_ready  = 1'b1;
    Load      = in_record;
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    cpu_run   = run_q;
    load_done = done_q;
    error     = err_q;
  end

endmodule
